// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared sizes, debounce FSM states and saturating increment
package input_conditioner_pkg;

  localparam int N_BTN            = 2;
  localparam int N_SW             = 4;
  localparam int PRESS_CNT_W      = 8;
  localparam int DEBOUNCE_DEFAULT = 50000;

  typedef enum logic {
    DB_IDLE,
    DB_COUNTING
  } db_state_t;

  function automatic logic [PRESS_CNT_W-1:0] sat_inc(input logic [PRESS_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one input bit: 2-flop synchronizer, stability counter, accepted level
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level;
  db_state_t     state;
  logic [CW-1:0] cnt;

  // The resting level of the raw input maps to 0, so buttons come out inverted.
  assign level = sync_q[1] ^ RESET_VAL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= DB_IDLE;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      rise <= 1'b0;
      case (state)
        DB_IDLE: begin
          if (level != stable) begin
            state <= DB_COUNTING;
            cnt   <= CW'(1);
          end
        end
        DB_COUNTING: begin
          if (level == stable) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            stable <= level;
            rise   <= level;
            cnt    <= '0;
            state  <= DB_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounces buttons and DIP switches, counts button presses
// Press counters are built only when INPUT_CONDITIONER_PRESS_COUNT_EN is defined.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [N_BTN-1:0]             key_n_i,
  input  logic [N_SW-1:0]              sw_i,
  output logic [N_BTN-1:0]             btn_o,
  output logic [N_SW-1:0]              sw_o,
  output logic [N_BTN-1:0]             btn_press_o,
  input  logic                         cnt_clr_i,
  output logic [N_BTN*PRESS_CNT_W-1:0] press_cnt_o
);

  logic [N_SW-1:0] sw_rise_unused;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1)
    ) u_db (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .raw   (key_n_i[i]),
      .stable(btn_o[i]),
      .rise  (btn_press_o[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0)
    ) u_db (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .raw   (sw_i[i]),
      .stable(sw_o[i]),
      .rise  (sw_rise_unused[i])
    );
  end

`ifdef INPUT_CONDITIONER_PRESS_COUNT_EN
  logic [N_BTN-1:0][PRESS_CNT_W-1:0] press_cnt;

  // A clear in the same cycle as a press leaves that press counted.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      press_cnt <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (cnt_clr_i) begin
          press_cnt[i] <= btn_press_o[i] ? PRESS_CNT_W'(1) : '0;
        end else if (btn_press_o[i]) begin
          press_cnt[i] <= sat_inc(press_cnt[i]);
        end
      end
    end
  end

  assign press_cnt_o = press_cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign press_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench: expected output changes queued by stimulus, checked by monitor
module tb_input_conditioner;

  localparam int DB = 4;
`ifdef INPUT_CONDITIONER_PRESS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  key_n = 2'b11;
  logic [3:0]  sw    = 4'b0000;
  logic        clr   = 1'b0;
  logic [1:0]  btn_o;
  logic [3:0]  sw_o;
  logic [1:0]  press_o;
  logic [15:0] cnt_o;

  input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .key_n_i      (key_n),
    .sw_i         (sw),
    .btn_o        (btn_o),
    .sw_o         (sw_o),
    .btn_press_o  (press_o),
    .cnt_clr_i    (clr),
    .press_cnt_o  (cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [23:0] val;
  } ev_t;

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  logic [1:0] m_btn = 2'b00;
  logic [3:0] m_sw  = 4'b0000;
  logic [7:0] m_c [2];

  function automatic logic [15:0] mcnt();
    return CNT_EN ? {m_c[1], m_c[0]} : 16'h0000;
  endfunction

  task automatic push(input int dly, input logic [1:0] pr);
    ev_t e;
    e.cyc = cyc + dly;
    e.val = {m_btn, m_sw, pr, mcnt()};
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Press button b, optionally pulsing cnt_clr_i in the pulse cycle, then release it.
  task automatic press(input int b, input bit clr_with);
    @(negedge clk);
    key_n[b] = 1'b0;
    m_btn[b] = 1'b1;
    push(6, 2'(1 << b));
    tick(6);
    if (clr_with) begin
      clr    = 1'b1;
      m_c[0] = 8'd0;
      m_c[1] = 8'd0;
    end
    if (m_c[b] != 8'hff) m_c[b] = m_c[b] + 8'd1;
    push(1, 2'b00);
    @(negedge clk);
    clr = 1'b0;
    tick(2);
    key_n[b] = 1'b1;
    m_btn[b] = 1'b0;
    push(6, 2'b00);
    tick(8);
  endtask

  initial begin : monitor
    logic [23:0] last;
    logic [23:0] cur;
    ev_t         e;
    last = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = {btn_o, sw_o, press_o, cnt_o};
      if (cur !== last) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=%h", cyc, cur, last);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || cur !== e.val) begin
            n_fail++;
            $display("FAIL output_event got cyc=%0d val=%h required cyc=%0d val=%h",
                     cyc, cur, e.cyc, e.val);
          end
        end
        last = cur;
      end
    end
  end

  initial begin : stim
    logic [15:0] old_cnt;
    m_c[0] = 8'd0;
    m_c[1] = 8'd0;

    @(posedge clk);
    #1;
    check("reset_outputs", {btn_o, sw_o, press_o, cnt_o}, 24'h0);
    tick(3);
    check("reset_outputs_held", {btn_o, sw_o, press_o, cnt_o}, 24'h0);
    rst_n = 1'b1;
    tick(10);
    check("post_reset_outputs", {btn_o, sw_o, press_o, cnt_o}, 24'h0);

    press(0, 1'b0);

    // Three low samples is the longest glitch that must be rejected.
    @(negedge clk);
    key_n[0] = 1'b0;
    tick(3);
    key_n[0] = 1'b1;
    tick(10);

    @(negedge clk);
    sw   = 4'b1010;
    m_sw = 4'b1010;
    push(6, 2'b00);
    tick(10);

    @(negedge clk);
    old_cnt = mcnt();
    clr     = 1'b1;
    m_c[0]  = 8'd0;
    m_c[1]  = 8'd0;
    if (old_cnt != mcnt()) push(1, 2'b00);
    @(negedge clk);
    clr = 1'b0;
    tick(3);

    for (int i = 0; i < 300; i++) press(1, 1'b0);
    check("cnt_after_300", {8'h00, cnt_o}, {8'h00, (CNT_EN ? 16'hff00 : 16'h0000)});
    press(1, 1'b1);
    check("cnt_after_clr_press", {8'h00, cnt_o}, {8'h00, (CNT_EN ? 16'h0100 : 16'h0000)});

    // Reset two cycles into a pending button0 press, key held low throughout.
    @(negedge clk);
    key_n[0] = 1'b0;
    tick(2);
    rst_n  = 1'b0;
    m_btn  = 2'b00;
    m_sw   = 4'b0000;
    m_c[0] = 8'd0;
    m_c[1] = 8'd0;
    push(1, 2'b00);
    #1;
    check("reset_mid_count", {btn_o, sw_o, press_o, cnt_o}, 24'h0);
    tick(3);
    rst_n    = 1'b1;
    m_btn[0] = 1'b1;
    m_sw     = 4'b1010;
    push(6, 2'b01);
    tick(6);
    m_c[0] = 8'd1;
    push(1, 2'b00);
    tick(3);
    key_n[0] = 1'b1;
    m_btn[0] = 1'b0;
    push(6, 2'b00);
    tick(12);

    check("events_pending", 24'(q.size()), 24'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
